// File: rtl/fib_pkg.sv
// Shared definitions for the fib_sched slice: datapath widths, the largest
// index whose Fibonacci value fits in RES_W bits, and the scheduler states.
package fib_pkg;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned RES_W   = 20;
  localparam int unsigned MAX_IDX = 30;  // fib(31) = 1346269 overflows 20 bits

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} fib_sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        : per-requester request vector
//   last_grant : index of the previously granted requester (lowest priority)
//   gnt        : one-hot grant, first asserted req searching from last_grant+1
//   any        : at least one request present
module rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic [N_REQ-1:0] gnt,
  output logic             any
);

  logic [GW-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    gnt = '0;
    pos = '0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      pos = GW'((32'(last_grant) + k) % N_REQ);
      if (req[pos]) begin
        gnt      = '0;
        gnt[pos] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fib_sched.sv
// Round-robin scheduler sharing one fib engine among N_REQ requesters.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/req_idx : per-requester request and Fibonacci index
//   req_ready         : one-hot, one-cycle accept pulse
//   rsp_valid         : one-hot, one-cycle response pulse
//   rsp_result/err    : response payload, valid while rsp_valid is non-zero
//   engine_fault      : sticky timeout flag, cleared only by rst
//   fib_start/fib_i   : engine start pulse and index (held until response)
//   fib_done/result   : engine completion and result
// All outputs are registered. Arbitration runs in IDLE (no accept pending)
// and in RESP, so a rejected request frees the slot for an accept two
// cycles later.
module fib_sched
  import fib_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][IDX_W-1:0] req_idx,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [RES_W-1:0]            rsp_result,
  output logic                        rsp_err,
  output logic                        engine_fault,
  output logic                        fib_start,
  output logic [IDX_W-1:0]            fib_i,
  input  logic                        fib_done,
  input  logic [RES_W-1:0]            fib_result
);

  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT);

  fib_sched_state_t state, state_d;
  logic [GW-1:0]    g_q, g_d, last_grant, last_d, arb_ptr, gnt_idx;
  logic [IDX_W-1:0] idx_q, idx_d, fib_i_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [N_REQ-1:0] gnt, g_onehot, req_ready_d, rsp_valid_d;
  logic [RES_W-1:0] rsp_result_d;
  logic             any, arbitrate, rsp_err_d, fault_d, fib_start_d;

  // In RESP the pointer register has not yet taken g_q, so use it directly.
  assign arb_ptr  = (state == RESP) ? g_q : last_grant;
  assign g_onehot = N_REQ'(1) << g_q;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (arb_ptr),
    .gnt        (gnt),
    .any        (any)
  );

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++)
      if (gnt[i]) gnt_idx = GW'(i);
  end

  always_comb begin
    state_d      = state;
    g_d          = g_q;
    idx_d        = idx_q;
    last_d       = last_grant;
    cnt_d        = cnt;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result;
    rsp_err_d    = rsp_err;
    fault_d      = engine_fault;
    fib_start_d  = 1'b0;
    fib_i_d      = fib_i;
    arbitrate    = 1'b0;
    case (state)
      IDLE: begin
        if (req_ready != '0) begin
          if (idx_q > IDX_W'(MAX_IDX) || engine_fault) begin
            state_d      = RESP;
            rsp_valid_d  = g_onehot;
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
          end else begin
            state_d     = ISSUE;
            fib_start_d = 1'b1;
            fib_i_d     = idx_q;
          end
        end else begin
          arbitrate = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt + 1'b1;
        if (fib_done) begin
          state_d      = RESP;
          rsp_valid_d  = g_onehot;
          rsp_result_d = fib_result;
          rsp_err_d    = 1'b0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_d      = RESP;
          fault_d      = 1'b1;
          rsp_valid_d  = g_onehot;
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
        end
      end
      RESP: begin
        last_d    = g_q;
        state_d   = IDLE;
        arbitrate = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (arbitrate && any) begin
      req_ready_d = gnt;
      g_d         = gnt_idx;
      idx_d       = req_idx[gnt_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      g_q          <= '0;
      idx_q        <= '0;
      last_grant   <= GW'(N_REQ - 1);
      cnt          <= '0;
      req_ready    <= '0;
      rsp_valid    <= '0;
      rsp_result   <= '0;
      rsp_err      <= 1'b0;
      engine_fault <= 1'b0;
      fib_start    <= 1'b0;
      fib_i        <= '0;
    end else begin
      state        <= state_d;
      g_q          <= g_d;
      idx_q        <= idx_d;
      last_grant   <= last_d;
      cnt          <= cnt_d;
      req_ready    <= req_ready_d;
      rsp_valid    <= rsp_valid_d;
      rsp_result   <= rsp_result_d;
      rsp_err      <= rsp_err_d;
      engine_fault <= fault_d;
      fib_start    <= fib_start_d;
      fib_i        <= fib_i_d;
    end
  end

endmodule

// File: tb/tb_fib_sched.sv
module tb_fib_sched;
  localparam int N   = 4;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0][4:0] req_idx = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [19:0]     rsp_result;
  logic            rsp_err, engine_fault, fib_start;
  logic [4:0]      fib_i;
  logic            fib_done = 1'b0;
  logic [19:0]     fib_result = '0;

  fib_sched #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_idx(req_idx),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .engine_fault(engine_fault), .fib_start(fib_start),
    .fib_i(fib_i), .fib_done(fib_done), .fib_result(fib_result)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  int fib_tab[32];

  // reference model / scoreboard state
  int          ptr = N - 1;
  bit          model_fault = 0;
  bit          hang = 0;
  bit          late_pulse = 0;
  int          eng_lat = 2;
  int          eng_cnt = 0;
  bit          eng_busy = 0;
  bit          fl_valid = 0, fl_skip = 0;
  int          fl_req, fl_acc, fl_cyc;
  logic [4:0]  fl_idx;
  logic [19:0] fl_res;
  logic        fl_err;
  int          n_rsp = 0, n_acc = 0, n_starts = 0, last_drop = -1;
  int          acc_per[N];
  logic [N-1:0] last_rsp_valid;
  logic [19:0] last_rsp_result;
  logic        last_rsp_err;
  logic [4:0]  last_start_i;
  int          rsp_req_q[$];
  int          rsp_res_q[$];

  function automatic int fib_ref(int n);
    if (n < 2) return n;
    return fib_ref(n - 1) + fib_ref(n - 2);
  endfunction

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (p + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // One clock cycle: engine stub, response/start/accept scoreboard.
  task automatic step();
    logic [N-1:0] arb_valid, exp_v;
    int g, a;
    arb_valid = req_valid;
    @(negedge clk);
    cyc++;
    last_drop = -1;
    fib_done  = 1'b0;
    if (late_pulse) begin
      fib_done   = 1'b1;
      fib_result = 20'hABCDE;
      late_pulse = 0;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        fib_done   = 1'b1;
        fib_result = 20'(fib_tab[fib_i]);
        fl_cyc     = cyc + 1;
      end
    end

    if (rsp_valid !== '0) begin
      n_cmp++;
      n_rsp++;
      last_rsp_valid  = rsp_valid;
      last_rsp_result = rsp_result;
      last_rsp_err    = rsp_err;
      if (!fl_valid) begin
        n_fail++;
        $display("FAIL rsp_orphan: rsp_valid=%b at cycle %0d, required no response", rsp_valid, cyc);
      end else begin
        exp_v = N'(1) << fl_req;
        rsp_req_q.push_back(fl_req);
        rsp_res_q.push_back(int'(rsp_result));
        if (rsp_valid !== exp_v || rsp_result !== fl_res || rsp_err !== fl_err ||
            cyc != fl_cyc || engine_fault !== model_fault) begin
          n_fail++;
          $display("FAIL rsp_check: valid=%b result=%0d err=%b cyc=%0d fault=%b, required valid=%b result=%0d err=%b cyc=%0d fault=%b",
                   rsp_valid, rsp_result, rsp_err, cyc, engine_fault,
                   exp_v, fl_res, fl_err, fl_cyc, model_fault);
        end
        fl_valid = 0;
        eng_busy = 0;
      end
    end

    if (fib_start === 1'b1) begin
      n_cmp++;
      n_starts++;
      last_start_i = fib_i;
      if (!fl_valid || fl_skip || eng_busy || fib_i !== fl_idx || cyc != fl_acc + 1) begin
        n_fail++;
        $display("FAIL start_check: fib_i=%0d cyc=%0d busy=%b pending=%b skip=%b, required fib_i=%0d cyc=%0d for one pending engine request",
                 fib_i, cyc, eng_busy, fl_valid, fl_skip, fl_idx, fl_acc + 1);
      end
      eng_busy = 1;
      if (!hang) eng_cnt = eng_lat;
    end

    if (req_ready !== '0) begin
      n_cmp++;
      g = rr_pick(arb_valid, ptr);
      exp_v = (g < 0) ? '0 : (N'(1) << g);
      if (req_ready !== exp_v || fl_valid) begin
        n_fail++;
        $display("FAIL grant_check: req_ready=%b busy=%b, required %b with nothing in flight (valid %b, ptr %0d)",
                 req_ready, fl_valid, exp_v, arb_valid, ptr);
      end
      a = 0;
      for (int i = N - 1; i >= 0; i--) if (req_ready[i]) a = i;
      fl_valid = 1;
      fl_req   = a;
      fl_acc   = cyc;
      fl_idx   = req_idx[a];
      if (fl_idx > 30 || model_fault) begin
        fl_skip = 1; fl_err = 1; fl_res = '0; fl_cyc = cyc + 1;
      end else if (hang) begin
        fl_skip = 0; fl_err = 1; fl_res = '0; fl_cyc = cyc + TMO + 2;
        model_fault = 1;
      end else begin
        fl_skip = 0; fl_err = 0; fl_res = 20'(fib_tab[fl_idx]); fl_cyc = -1;
      end
      ptr          = a;
      req_valid[a] = 1'b0;
      last_drop    = a;
      n_acc++;
      acc_per[a]++;
    end
  endtask

  task automatic run_quiet(int maxc, string name);
    int k;
    k = 0;
    while ((fl_valid || req_valid != '0) && k < maxc) begin
      step();
      k++;
    end
    n_cmp++;
    if (fl_valid || req_valid != '0) begin
      n_fail++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, maxc);
    end
  endtask

  task automatic clear_model();
    ptr = N - 1; model_fault = 0; fl_valid = 0; eng_busy = 0; eng_cnt = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) step();
    clear_model();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({req_ready, rsp_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_vec: req_ready=%b rsp_valid=%b, required 0", req_ready, rsp_valid);
    end
    n_cmp++;
    if ({rsp_result, fib_i} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rsp_result=%0d fib_i=%0d, required 0", rsp_result, fib_i);
    end
    n_cmp++;
    if ({rsp_err, engine_fault, fib_start} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: err=%b fault=%b start=%b, required 000", rsp_err, engine_fault, fib_start);
    end
    clear_model();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int s0;
    s0 = n_starts;
    eng_lat = 3;
    req_valid[0] = 1'b1; req_idx[0] = 5'd10;
    run_quiet(50, "single");
    n_cmp++;
    if (last_rsp_valid !== 4'b0001 || last_rsp_result !== 20'd55 || last_rsp_err !== 1'b0 ||
        n_starts != s0 + 1 || last_start_i !== 5'd10) begin
      n_fail++;
      $display("FAIL single: valid=%b result=%0d err=%b starts=%0d fib_i=%0d, required 0001/55/0/1/10",
               last_rsp_valid, last_rsp_result, last_rsp_err, n_starts - s0, last_start_i);
    end
  endtask

  task automatic test_round_robin();
    int exp_res[4] = '{6765, 1, 0, 832040};
    apply_reset();
    for (int i = 0; i < N; i++) acc_per[i] = 0;
    rsp_req_q.delete(); rsp_res_q.delete();
    eng_lat = 2;
    req_idx[0] = 5'd20; req_idx[1] = 5'd1; req_idx[2] = 5'd0; req_idx[3] = 5'd30;
    req_valid = '1;
    run_quiet(100, "round_robin");
    n_cmp++;
    if (rsp_req_q.size() != 4) begin
      n_fail++;
      $display("FAIL rr_count: %0d responses, required 4", rsp_req_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (rsp_req_q[i] != i || rsp_res_q[i] != exp_res[i] || acc_per[i] != 1) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: req=%0d result=%0d accepts=%0d, required req=%0d result=%0d accepts=1",
                   i, rsp_req_q[i], rsp_res_q[i], acc_per[i], i, exp_res[i]);
        end
      end
    end
  endtask

  task automatic test_bound();
    int s0;
    s0 = n_starts;
    req_valid[2] = 1'b1; req_idx[2] = 5'd31;
    run_quiet(20, "bound");
    n_cmp++;
    if (last_rsp_valid !== 4'b0100 || last_rsp_err !== 1'b1 || last_rsp_result !== '0 || n_starts != s0) begin
      n_fail++;
      $display("FAIL bound: valid=%b err=%b result=%0d starts=%0d, required 0100/1/0/0",
               last_rsp_valid, last_rsp_err, last_rsp_result, n_starts - s0);
    end
  endtask

  task automatic test_timeout();
    int s0, r0;
    hang = 1;
    req_valid[1] = 1'b1; req_idx[1] = 5'd5;
    run_quiet(200, "timeout");
    n_cmp++;
    if (engine_fault !== 1'b1 || last_rsp_err !== 1'b1 || last_rsp_valid !== 4'b0010) begin
      n_fail++;
      $display("FAIL timeout: fault=%b err=%b valid=%b, required 1/1/0010", engine_fault, last_rsp_err, last_rsp_valid);
    end
    r0 = n_rsp;
    late_pulse = 1;
    repeat (5) step();
    n_cmp++;
    if (n_rsp != r0 || engine_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL late_done: %0d responses fault=%b, required 0 responses fault=1", n_rsp - r0, engine_fault);
    end
    s0 = n_starts;
    req_valid[2] = 1'b1; req_idx[2] = 5'd3;
    run_quiet(20, "fault_reject");
    n_cmp++;
    if (n_starts != s0 || last_rsp_err !== 1'b1 || last_rsp_valid !== 4'b0100) begin
      n_fail++;
      $display("FAIL fault_reject: starts=%0d err=%b valid=%b, required 0/1/0100", n_starts - s0, last_rsp_err, last_rsp_valid);
    end
    hang = 0;
  endtask

  task automatic test_reset_mid();
    int s0, r0, k;
    apply_reset();
    eng_lat = 30;
    s0 = n_starts;
    req_valid[1] = 1'b1; req_idx[1] = 5'd20;
    k = 0;
    while (n_starts == s0 && k < 20) begin step(); k++; end
    step();
    rst = 1'b1;
    eng_cnt = 0;
    step();
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_result, rsp_err, engine_fault, fib_start, fib_i} !== '0 || n_starts == s0) begin
      n_fail++;
      $display("FAIL reset_mid: ready=%b rsp=%b result=%0d err=%b fault=%b start=%b fib_i=%0d started=%0d, required all 0 after a start",
               req_ready, rsp_valid, rsp_result, rsp_err, engine_fault, fib_start, fib_i, n_starts - s0);
    end
    clear_model();
    rst = 1'b0;
    r0 = n_rsp;
    repeat (40) step();
    n_cmp++;
    if (n_rsp != r0) begin
      n_fail++;
      $display("FAIL reset_drop: %0d responses after reset, required 0", n_rsp - r0);
    end
    eng_lat = 3;
    req_valid[3] = 1'b1; req_idx[3] = 5'd7;
    run_quiet(50, "post_reset");
    n_cmp++;
    if (last_rsp_valid !== 4'b1000 || last_rsp_result !== 20'd13 || last_rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: valid=%b result=%0d err=%b, required 1000/13/0", last_rsp_valid, last_rsp_result, last_rsp_err);
    end
  endtask

  task automatic test_soak();
    int issued, a0, r0, k;
    issued = 0; a0 = n_acc; r0 = n_rsp; k = 0;
    while ((n_acc - a0 < 1000 || fl_valid) && k < 40000) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && i != last_drop && issued < 1000 && $urandom_range(0, 3) == 0) begin
          req_idx[i]   = 5'($urandom_range(0, 31));
          req_valid[i] = 1'b1;
          issued++;
        end
      end
      eng_lat = $urandom_range(1, 6);
      step();
      k++;
    end
    n_cmp++;
    if (n_acc - a0 != 1000 || n_rsp - r0 != 1000 || fl_valid) begin
      n_fail++;
      $display("FAIL soak_count: accepts=%0d responses=%0d pending=%b, required 1000/1000/0",
               n_acc - a0, n_rsp - r0, fl_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) fib_tab[i] = fib_ref(i);
    for (int i = 0; i < N; i++) acc_per[i] = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_bound();
    test_timeout();
    test_reset_mid();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_sched.md
# fib_sched

Round-robin scheduler that shares one `fib` engine among `N_REQ` requesters. It accepts one index per handshake and sequences the engine's `start`/`done` protocol. It returns the 20-bit result, or an error, to the requester that issued the index. It sits between client blocks and the single `fib` instance, so the engine never receives overlapping starts.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 64: maximum cycles in WAIT before the block declares an engine fault.
- `clk` in 1: the block's single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N_REQ: per-requester request.
- `req_idx` in N_REQ×5: per-requester Fibonacci index.
- `req_ready` out N_REQ: one-hot, one-cycle accept pulse.
- `rsp_valid` out N_REQ: one-hot, one-cycle response pulse.
- `rsp_result` out 20: result; valid only while `rsp_valid` is non-zero.
- `rsp_err` out 1: error flag qualifying the response.
- `engine_fault` out 1: sticky, set on timeout, cleared only by `rst`.
- `fib_start` out 1: engine start pulse.
- `fib_i` out 5: engine index, held stable from ISSUE until the response.
- `fib_done` in 1: engine completion.
- `fib_result` in 20: engine result; valid while `fib_done` is high.

## Operation
- **Engine contract:** `fib_done` deasserts within one cycle of `fib_start`. The scheduler never samples `fib_done` in the ISSUE cycle.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Select the first asserted `req_valid` searching from `last_grant+1` modulo N_REQ.
  - Pulse `req_ready[g]` for that cycle; the handshake completes on `req_valid[g] & req_ready[g]`.
  - Latch `g` and `req_idx[g]`.
  - If the latched index is > MAX_IDX (30), or `engine_fault` is set, go to RESP with err=1 and skip the engine. fib(31) overflows 20 bits.
  - Otherwise go to ISSUE.
- **ISSUE:** `fib_start=1` for exactly one cycle; clear the timeout counter; go to WAIT.
- **WAIT:**
  - Counter increments each cycle.
  - On `fib_done=1`, capture `fib_result` and go to RESP with err=0.
  - If the counter reaches TIMEOUT-1 without `fib_done`, set `engine_fault` and go to RESP with err=1, result 0.
- **RESP:**
  - `rsp_valid[g]=1` for one cycle, with `rsp_result` and `rsp_err` driven.
  - `last_grant<=g`; go to IDLE.
  - There is no response backpressure: requesters must take the pulse.
- **Requester obligations:** hold `req_valid` and `req_idx` until `req_ready`, and drop `req_valid` the cycle after. A requester that re-asserts `req_valid` is re-arbitrated normally.
- **Fairness:** the granted requester has lowest priority next round. With all N_REQ requesting continuously, each is served once per N_REQ transactions.
- **Late done:** after a fault, a late `fib_done` is ignored. The engine is not restarted until `rst`.
- **Reset:**
  - Reset mid-operation returns to IDLE.
  - All outputs go to 0 and `engine_fault` clears.
  - `last_grant=N_REQ-1`, so requester 0 has first priority after reset.
  - Any in-flight request is dropped without response.

## Timing
- Accept in cycle t (IDLE).
- `fib_start` in t+1.
- WAIT from t+2.
- `fib_done` first seen in cycle d gives `rsp_valid` in d+1; IDLE again in d+2.
- Rejected or faulted requests: accept in t, response in t+1, next accept earliest t+2.
- Timeout: the response comes exactly TIMEOUT+2 cycles after accept.
- Reset values:
  - `req_ready`, `rsp_valid`, `rsp_err`, `fib_start`, `engine_fault`: 0.
  - `rsp_result` and `fib_i`: 0.
- Outputs are all registered; there is no combinational path from `req_*` or `fib_*` to any output.

## Structure
- **`fib_pkg`:**
  - `IDX_W=5`, `RES_W=20`, `MAX_IDX=30`.
  - `typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} fib_sched_state_t`.
- **`rr_arbiter` sub-module:**
  - Inputs: `req[N_REQ]`, pointer `last_grant`.
  - Output: one-hot `gnt`, plus `any`.
  - Purely combinational; the pointer register lives in `fib_sched`.
- **Bench reference:** reuses the recursive reference model for expected values.

## Test plan
- **Single request:** requester 0, idx 10, after reset → `fib_start` one cycle later with `fib_i=10`; `rsp_valid=4'b0001`, `rsp_result=55`, err=0.
- **Round-robin:** all 4 request (idx 20, 1, 0, 30) simultaneously → served in order 0,1,2,3 with results 6765, 1, 0, 832040. Each `req_ready` pulses exactly once, and no two transactions overlap on `fib_start`.
- **Bound check:** idx 31 from requester 2 → response one cycle after accept with err=1 and result 0; `fib_start` never pulses.
- **Timeout:** stub engine never asserts done; idx 5 → `rsp_err=1` exactly TIMEOUT+2 cycles after accept and `engine_fault=1`. A following idx 3 request → immediate err response with no `fib_start`.
- **Reset mid-operation:** `rst` asserted during WAIT → all outputs 0 next cycle and no response for the dropped request. Post-reset idx 7 from requester 3 → result 13.
- **Random soak:** 1000 random indices 0..31 on random requesters → every response matches the reference model (err for idx 31), with one response per accept.
